// File: rtl/serbuf_pkg.sv
// Shared types and constants for the serial operand buffer.
// Build option: define SERIAL_BUF_RESULT_CAPTURE_EN to capture ALU results and drain them.
package serbuf_pkg;

    // Buffer sequencing states; the DRAIN states are only reachable when capture is enabled.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_HI  = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_DRAIN_LO = 3'd3,
        ST_DRAIN_HI = 3'd4
    } state_e;

    // ALU steps needed to stream a one-byte or two-byte operand (default 8-bit bytes, 2 bits per step).
    localparam int unsigned STEPS_BYTE = 4;
    localparam int unsigned STEPS_PAIR = 8;

    // Step counter width; holds STEPS_PAIR plus headroom for the overrun check.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/serbuf_shreg.sv
// Operand/result shift register: byte loads, right shift by NSHIFT with top insertion.
// Insertion lands at the top of the active width (one byte or two bytes, chosen by i_pair).
// Build option SERIAL_BUF_RESULT_CAPTURE_EN is resolved by the parent, which supplies i_ins.
module serbuf_shreg
#(
    parameter int unsigned REG_BITS = 8,
    parameter int unsigned NSHIFT   = 2
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load_lo,
    input  logic                  i_load_hi,
    input  logic                  i_shift,
    input  logic                  i_pair,
    input  logic [REG_BITS-1:0]   i_data,
    input  logic [NSHIFT-1:0]     i_ins,
    output logic [2*REG_BITS-1:0] o_sreg
);
    import serbuf_pkg::*;

    logic [2*REG_BITS-1:0] r_sreg;
    logic [2*REG_BITS-1:0] w_shifted;

    // Next shifted value: the high byte is left alone for one-byte operands.
    always_comb begin
        w_shifted = r_sreg;
        if (i_pair) begin
            w_shifted = {i_ins, r_sreg[2*REG_BITS-1:NSHIFT]};
        end else begin
            w_shifted[REG_BITS-1:0] = {i_ins, r_sreg[REG_BITS-1:NSHIFT]};
        end
    end

    // Register update: byte loads from the bus, or one shift step from the ALU.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            r_sreg <= '0;
        end else if (i_load_lo) begin
            r_sreg[REG_BITS-1:0] <= i_data;
        end else if (i_load_hi) begin
            r_sreg[2*REG_BITS-1:REG_BITS] <= i_data;
        end else if (i_shift) begin
            r_sreg <= w_shifted;
        end
    end

    assign o_sreg = r_sreg;

endmodule

// File: rtl/serial_operand_buffer.sv
// Serial operand buffer: loads a 1- or 2-byte operand, streams it to a bit-serial ALU
// NSHIFT bits per active cycle, and checks that the ALU finishes on the right step.
// Build option SERIAL_BUF_RESULT_CAPTURE_EN: when defined, ALU result bits are shifted
// back in and drained as bytes; when undefined, results are discarded and the buffer
// returns to IDLE as soon as the ALU signals completion.
module serial_operand_buffer
#(
    parameter int unsigned REG_BITS = 8,
    parameter int unsigned NSHIFT   = 2
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_BITS-1:0] in_data,
    input  logic                in_pair,
    output logic                operand_ready,
    input  logic                alu_active,
    input  logic                alu_op_done,
    output logic [NSHIFT-1:0]   data_in,
    input  logic [NSHIFT-1:0]   data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REG_BITS-1:0] out_data,
    output logic                err
);
    import serbuf_pkg::*;

    localparam logic [CNT_W-1:0] STEPS_B = CNT_W'(STEPS_BYTE);
    localparam logic [CNT_W-1:0] STEPS_P = CNT_W'(STEPS_PAIR);

    state_e                r_state;
    state_e                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pair;
    logic                  r_err;

    logic [2*REG_BITS-1:0] w_sreg;
    logic [CNT_W-1:0]      w_steps;
    logic                  w_steps_left;
    logic                  w_load_lo;
    logic                  w_load_hi;
    logic                  w_shift;
    logic                  w_err_set;
    logic                  w_in_ready;
    logic                  w_operand_ready;
    logic                  w_out_valid;
    logic [REG_BITS-1:0]   w_out_data;
    logic [NSHIFT-1:0]     w_ins;
    logic [NSHIFT-1:0]     w_data_in;

    assign w_steps      = r_pair ? STEPS_P : STEPS_B;
    assign w_steps_left = (r_cnt < w_steps);

`ifdef SERIAL_BUF_RESULT_CAPTURE_EN
    assign w_ins = data_out;
`else
    // Results are not kept, so the vacated top bits fill with zeros.
    assign w_ins = '0;
    logic w_unused;
    assign w_unused = ^{data_out, out_ready, w_sreg[2*REG_BITS-1:NSHIFT]};
`endif

    serbuf_shreg #(
        .REG_BITS (REG_BITS),
        .NSHIFT   (NSHIFT)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load_lo (w_load_lo),
        .i_load_hi (w_load_hi),
        .i_shift   (w_shift),
        .i_pair    (r_pair),
        .i_data    (in_data),
        .i_ins     (w_ins),
        .o_sreg    (w_sreg)
    );

    // Next-state and per-state control; everything defaults to idle/inactive.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        w_state_next    = r_state;
        w_load_lo       = 1'b0;
        w_load_hi       = 1'b0;
        w_shift         = 1'b0;
        w_err_set       = 1'b0;
        w_in_ready      = 1'b0;
        w_operand_ready = 1'b0;
        w_out_valid     = 1'b0;
        w_out_data      = '0;

        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load_lo    = 1'b1;
                    w_state_next = in_pair ? ST_LOAD_HI : ST_SHIFT;
                end
            end
            ST_LOAD_HI: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load_hi    = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_operand_ready = 1'b1;
                if (alu_active) begin
                    // Once all operand bits are out, the register freezes.
                    w_shift = w_steps_left;
                    if (alu_op_done) begin
                        w_err_set = ((r_cnt + CNT_W'(1)) != w_steps);
`ifdef SERIAL_BUF_RESULT_CAPTURE_EN
                        w_state_next = ST_DRAIN_LO;
`else
                        w_state_next = ST_IDLE;
`endif
                    end
                end
            end
`ifdef SERIAL_BUF_RESULT_CAPTURE_EN
            ST_DRAIN_LO: begin
                w_out_valid = 1'b1;
                w_out_data  = w_sreg[REG_BITS-1:0];
                if (out_ready) begin
                    w_state_next = r_pair ? ST_DRAIN_HI : ST_IDLE;
                end
            end
            ST_DRAIN_HI: begin
                w_out_valid = 1'b1;
                w_out_data  = w_sreg[2*REG_BITS-1:REG_BITS];
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, step counter, operand size and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pair  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load_lo) begin
                r_pair <= in_pair;
                r_cnt  <= '0;
            end else if (w_shift) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Operand bits only drive the ALU while there are steps left to deliver.
    assign w_data_in = ((r_state == ST_SHIFT) && w_steps_left) ? w_sreg[NSHIFT-1:0] : '0;

    assign in_ready      = w_in_ready;
    assign operand_ready = w_operand_ready;
    assign data_in       = w_data_in;
    assign out_valid     = w_out_valid;
    assign out_data      = w_out_data;
    assign err           = r_err;

endmodule

// File: tb/tb_serial_operand_buffer.sv
// Self-checking bench for serial_operand_buffer (default geometry: 8-bit bytes, 2 bits per step).
// Exercises whichever build SERIAL_BUF_RESULT_CAPTURE_EN selects.
module tb_serial_operand_buffer;

    localparam int REG_BITS = 8;
    localparam int NSHIFT   = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [REG_BITS-1:0] in_data;
    logic                in_pair;
    logic                operand_ready;
    logic                alu_active;
    logic                alu_op_done;
    logic [NSHIFT-1:0]   data_in;
    logic [NSHIFT-1:0]   data_out;
    logic                out_valid;
    logic                out_ready;
    logic [REG_BITS-1:0] out_data;
    logic                err;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: expected ALU-bound digits, and (with capture) expected result bytes.
    logic [1:0] q_din[$];
`ifdef SERIAL_BUF_RESULT_CAPTURE_EN
    logic [7:0] q_out[$];
`endif

    typedef struct {
        logic        pair;
        logic [15:0] operand;
        int          gap;
        int          done_step;
        int          stall;
        logic        exp_err;
        logic        noise;
    } vec_t;

    vec_t vecs[6];

    serial_operand_buffer #(
        .REG_BITS (REG_BITS),
        .NSHIFT   (NSHIFT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_pair       (in_pair),
        .operand_ready (operand_ready),
        .alu_active    (alu_active),
        .alu_op_done   (alu_op_done),
        .data_in       (data_in),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

`ifdef SERIAL_BUF_RESULT_CAPTURE_EN
    // Loopback result: operand rotated right by 2 bits per delivered step within its width.
    function automatic logic [15:0] rot_result(input logic pair, input logic [15:0] operand, input int k);
        int          w;
        int          steps;
        int          sh;
        logic [31:0] v;
        logic [31:0] mask;
        w     = pair ? 16 : 8;
        steps = pair ? 8 : 4;
        sh    = 2 * ((k < steps) ? k : steps);
        mask  = (32'd1 << w) - 32'd1;
        v     = {16'd0, operand} & mask;
        v     = ((v >> sh) | (v << (w - sh))) & mask;
        return v[15:0];
    endfunction
`endif

    // One full operation: load, stream with optional gaps and noise, then finish/drain.
    task automatic run_op(input logic pair, input logic [15:0] operand, input int gap,
                          input int done_step, input int stall, input logic exp_err,
                          input logic noise);
        int          steps;
        logic [31:0] opw;
        logic [1:0]  exp_d;
`ifdef SERIAL_BUF_RESULT_CAPTURE_EN
        logic [15:0] res;
        logic [7:0]  lo;
        logic [7:0]  hi;
`endif
        steps = pair ? 8 : 4;
        opw   = {16'd0, operand};
        for (int k = 0; k < done_step; k++) begin
            q_din.push_back((k < steps) ? 2'((opw >> (2 * k)) & 32'd3) : 2'd0);
        end
`ifdef SERIAL_BUF_RESULT_CAPTURE_EN
        res = rot_result(pair, operand, done_step);
        q_out.push_back(res[7:0]);
        if (pair) q_out.push_back(res[15:8]);
`endif

        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_pair  = pair;
        in_data  = operand[7:0];
        @(negedge clk);
        if (pair) begin
            check("in_ready_load_hi", in_ready, 1);
            check("operand_ready_load_hi", operand_ready, 0);
            in_data = operand[15:8];
            @(negedge clk);
        end
        in_valid = noise;
        in_pair  = ~pair;
        in_data  = 8'hEE;
        check("operand_ready_shift", operand_ready, 1);
        check("in_ready_shift", in_ready, 0);

        for (int s = 0; s < done_step; s++) begin
            exp_d = q_din.pop_front();
            check("data_in_step", data_in, exp_d);
            alu_active  = 1'b1;
            alu_op_done = (s == done_step - 1);
            data_out    = exp_d;
            @(negedge clk);
            alu_active  = 1'b0;
            alu_op_done = 1'b0;
            data_out    = 2'b11;
            if (s != done_step - 1) begin
                for (int g = 0; g < gap; g++) begin
                    alu_op_done = noise;
                    check("data_in_gap", data_in, q_din[0]);
                    check("operand_ready_gap", operand_ready, 1);
                    @(negedge clk);
                    alu_op_done = 1'b0;
                end
            end
        end
        in_valid = 1'b0;

`ifdef SERIAL_BUF_RESULT_CAPTURE_EN
        lo = q_out.pop_front();
        check("out_valid_lo", out_valid, 1);
        check("out_data_lo", out_data, lo);
        check("in_ready_drain", in_ready, 0);
        out_ready = 1'b0;
        for (int st = 0; st < stall; st++) begin
            @(negedge clk);
            check("out_valid_stall", out_valid, 1);
            check("out_data_stall", out_data, lo);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (pair) begin
            hi = q_out.pop_front();
            check("out_valid_hi", out_valid, 1);
            check("out_data_hi", out_data, hi);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("out_valid_done", out_valid, 0);
`else
        check("out_valid_done", out_valid, 0);
        check("out_data_done", out_data, 0);
        for (int st = 0; st < stall; st++) begin
            @(negedge clk);
            check("out_valid_idle", out_valid, 0);
        end
`endif
        check("in_ready_after", in_ready, 1);
        check("operand_ready_after", operand_ready, 0);
        check("data_in_after", data_in, 0);
        check("err_after", err, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 16'h00B4, 0, 4, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h1234, 2, 8, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h005A, 1, 4, 3, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'hA5C3, 1, 8, 1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'h00B4, 0, 2, 0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 16'h000F, 1, 4, 0, 1'b1, 1'b1};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_pair     = 1'b0;
        alu_active  = 1'b0;
        alu_op_done = 1'b0;
        data_out    = '0;
        out_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check("rst_in_ready", in_ready, 1);
        check("rst_operand_ready", operand_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_in", data_in, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].pair, vecs[i].operand, vecs[i].gap, vecs[i].done_step,
                   vecs[i].stall, vecs[i].exp_err, vecs[i].noise);
        end

        // Reset in the middle of streaming, three steps in; sticky error must clear.
        check("err_sticky_before_reset", err, 1);
        in_valid = 1'b1;
        in_pair  = 1'b0;
        in_data  = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("mid_data_in", data_in, (s == 0) ? 0 : 3);
            alu_active = 1'b1;
            data_out   = 2'b01;
            @(negedge clk);
        end
        alu_active = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_operand_ready", operand_ready, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_data_in", data_in, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);

        // Fresh operation after reset: step counter must restart from zero.
        run_op(1'b0, 16'h00C6, 1, 4, 0, 1'b0, 1'b0);
        // Overrun: op_done one step late; the extra step sees zero operand bits.
        run_op(1'b0, 16'h009C, 0, 5, 1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
